// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with LRU replacement, refill FSM,
// flush and fetch cancellation.
module icache_2way #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SET_BITS   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  input  logic                  fetch_clear,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data
);
  localparam int unsigned Sets = 1 << SET_BITS;
  localparam int unsigned TagW = ADDR_WIDTH - SET_BITS - 2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StMiss   = 2'd2;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:2] addr_q;
  logic                  cancel_q;
  logic                  flushed_q;
  logic [Sets-1:0]       valid0_q, valid1_q, lru_q;
  logic [TagW-1:0]       tag0_q  [Sets];
  logic [TagW-1:0]       tag1_q  [Sets];
  logic [DATA_WIDTH-1:0] data0_q [Sets];
  logic [DATA_WIDTH-1:0] data1_q [Sets];
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [SET_BITS-1:0]   idx;
  logic [TagW-1:0]       tag;
  logic                  hit0, hit1, victim, fill_we;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^fetch_addr[1:0];

  assign idx  = addr_q[SET_BITS+1:2];
  assign tag  = addr_q[ADDR_WIDTH-1:SET_BITS+2];
  assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);

  // Prefer an empty way; only fall back to LRU when both ways are occupied.
  assign victim = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

  // A flush seen at any point of the miss (including the ack edge) blocks the fill.
  assign fill_we = !rst && rdy && (state_q == StMiss) && mem_ack && !(flushed_q || flush);

  assign fetch_ready = (state_q == StIdle);
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cancel_q     <= 1'b0;
      flushed_q    <= 1'b0;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (rdy) begin
      resp_valid_q <= 1'b0;
      if (flush) begin
        valid0_q <= '0;
        valid1_q <= '0;
        lru_q    <= '0;
      end
      case (state_q)
        StIdle: begin
          if (fetch_valid) begin
            addr_q  <= fetch_addr[ADDR_WIDTH-1:2];
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit0 || hit1) begin
            resp_valid_q <= !fetch_clear;
            if (!fetch_clear) resp_data_q <= hit0 ? data0_q[idx] : data1_q[idx];
            if (!flush) lru_q[idx] <= hit0;
            state_q <= StIdle;
          end else if (fetch_clear) begin
            state_q <= StIdle;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {addr_q, 2'b00};
            cancel_q   <= 1'b0;
            flushed_q  <= 1'b0;
            state_q    <= StMiss;
          end
        end
        StMiss: begin
          if (fetch_clear) cancel_q <= 1'b1;
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            resp_valid_q <= !(cancel_q || fetch_clear);
            if (!(cancel_q || fetch_clear)) resp_data_q <= mem_data;
            mem_req_q <= 1'b0;
            cancel_q  <= 1'b0;
            flushed_q <= 1'b0;
            state_q   <= StIdle;
            if (fill_we) begin
              if (victim) valid1_q[idx] <= 1'b1;
              else        valid0_q[idx] <= 1'b1;
              lru_q[idx] <= ~victim;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      if (victim) begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= mem_data;
      end else begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= mem_data;
      end
    end
  end
endmodule
